// File: rtl/modmul_arbiter_pkg.sv
// Shared parameters for the modular-multiplier sharing block.
// Defaults match the NTT core configuration: 30-bit residues, 4-deep multiplier.
package modmul_arbiter_pkg;
  localparam int WIDTH_DEF        = 30;
  localparam int MULT_LATENCY_DEF = 4;
  localparam int NUM_REQ_DEF      = 4;
  localparam int ID_W_DEF         = 2;

  // NTT-friendly prime just below 2^30; reduction happens in the multiplier.
  localparam logic [WIDTH_DEF-1:0] Q = 30'd998244353;

  // Requester id width needed for n requesters (n >= 2).
  function automatic int id_width(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/modmul_arbiter_rr_arbiter.sv
// Round-robin arbiter: scans requests starting at the priority pointer and
// wraps; the pointer moves one past each winner and holds when idle.
module rr_arbiter
  import modmul_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ID_W    = ID_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id
);

  logic [ID_W-1:0] ptr;

  // Pick the first set request at or after ptr, modulo NUM_REQ.
  always_comb begin
    int  idx;
    logic found;
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && en && req[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = ID_W'(idx);
      end
    end
  end

  // Priority pointer: one past the last winner, so a waiting requester is
  // reached within NUM_REQ cycles.
  always_ff @(posedge clk) begin
    if (rst)
      ptr <= '0;
    else if (|grant)
      ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
  end

endmodule

// File: rtl/modmul_arbiter.sv
// Shares one pipelined modular multiplier among NUM_REQ requesters.
// One grant per cycle is registered into the multiplier; a tag pipe of the
// same depth returns each product to its requester with fixed latency.
module modmul_arbiter
  import modmul_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = NUM_REQ_DEF,
  parameter int WIDTH        = WIDTH_DEF,
  parameter int MULT_LATENCY = MULT_LATENCY_DEF,
  parameter int ID_W         = ID_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic [WIDTH-1:0]           mult_a,
  output logic [WIDTH-1:0]           mult_b,
  input  logic [WIDTH-1:0]           mult_c,
  output logic                       resp_valid,
  output logic [ID_W-1:0]            resp_id,
  output logic [WIDTH-1:0]           resp_data,
  output logic                       busy
);

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic [WIDTH-1:0]   sel_a, sel_b;

  // Index 0 is the issue stage (aligned with mult_a/mult_b); index
  // MULT_LATENCY lines up with the product on mult_c.
  logic [MULT_LATENCY:0]           vld_pipe;
  logic [MULT_LATENCY:0][ID_W-1:0] id_pipe;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      (req_valid),
    .en       (!rst),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign req_ready = grant;

  // Winner's operands.
  always_comb begin
    sel_a = req_a[grant_id*WIDTH +: WIDTH];
    sel_b = req_b[grant_id*WIDTH +: WIDTH];
  end

  // Issue register: operands hold when idle so the multiplier inputs stay quiet.
  always_ff @(posedge clk) begin
    if (rst) begin
      mult_a <= '0;
      mult_b <= '0;
    end else if (|grant) begin
      mult_a <= sel_a;
      mult_b <= sel_b;
    end
  end

  // Tag pipe shifts every cycle; reset drops all tags so draining products
  // never surface as responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[MULT_LATENCY-1:0], |grant};
      id_pipe  <= {id_pipe[MULT_LATENCY-1:0], grant_id};
    end
  end

  assign resp_valid = vld_pipe[MULT_LATENCY] & !rst;
  assign resp_id    = id_pipe[MULT_LATENCY];
  assign resp_data  = mult_c;
  assign busy       = (|vld_pipe) & !rst;

endmodule

// File: doc/modmul_arbiter.md
Name: modmul_arbiter

Overview:
- Shares one pipelined modular_multiplier instance (30-bit operands) between NUM_REQ requesters, e.g. butterfly units and the twiddle-factor generator of the NTT core.
- Each cycle a round-robin arbiter grants at most one request and registers its operands into the multiplier.
- A tag pipeline matched to the multiplier depth steers each product back to its requester with a fixed latency.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 30, operand/result width (residues mod q).
- MULT_LATENCY, 4, clock cycles from the multiplier's a/b inputs to c. Must equal the pipeline depth of the instantiated modular_multiplier configuration.
- ID_W, 2, requester id width, equal to clog2(NUM_REQ).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester grant; a handshake occurs when valid and ready are both high.
- req_a  in  NUM_REQ*WIDTH  operand a, requester i at bits [i*WIDTH +: WIDTH].
- req_b  in  NUM_REQ*WIDTH  operand b, same packing as req_a.
- mult_a  out  WIDTH  registered operand a to the multiplier.
- mult_b  out  WIDTH  registered operand b to the multiplier.
- mult_c  in  WIDTH  product returned from the multiplier.
- resp_valid  out  1  a product is present on resp_data this cycle.
- resp_id  out  ID_W  requester the product belongs to.
- resp_data  out  WIDTH  product, equal to mult_c.
- busy  out  1  any operation issued or in flight.

Behaviour:
- Reset: applies on a clk edge with rst=1. Clears mult_a, mult_b, the issue-valid bit, all tag-pipe stages and the priority pointer to 0.
  - While rst=1: req_ready=0, resp_valid=0, busy=0.
- Arbitration: combinational. Scans req_valid starting at pointer ptr and wraps modulo NUM_REQ; the first set bit wins.
  - req_ready is one-hot or all-zero, and is zero when rst=1.
  - After a grant to i: ptr <= (i+1) mod NUM_REQ. With no request, ptr holds.
- Issue stage (edge after a handshake at cycle t):
  - mult_a/mult_b <= the winner's operands.
  - issue_vld <= 1, issue_id <= winner.
  - With no grant: issue_vld <= 0 and mult_a/mult_b hold their previous values.
- Tag pipe: MULT_LATENCY stages of {vld,id}, fed from {issue_vld,issue_id}. It shifts every cycle with no stall.
- Response: resp_valid/resp_id come from the final tag stage. resp_data = mult_c, combinational pass-through.
  - A handshake at cycle t produces resp_valid at cycle t+1+MULT_LATENCY.
  - Responses leave in grant order. There is no response backpressure; the destination must accept.
- Throughput: one operation per cycle sustained. A requester holding req_valid is served at least once every NUM_REQ cycles.
- No arithmetic in this block. Reduction mod q happens in the multiplier. Operands must be < q; inputs >= q are not checked.
- busy = issue_vld OR any tag-stage vld.
- Simultaneous requests: exactly one grant. All other requesters must hold req_valid and their operands stable until granted.
- Reset mid-operation: all tags are dropped, so products still draining through the multiplier never raise resp_valid. The next grant goes to the lowest-index valid requester.
- Requester dropping req_valid before it is granted: legal; no operation is issued for it.

Decomposition:
- Shared header ntt_params.vh holds WIDTH=30, modulus Q, MULT_LATENCY and NUM_REQ/ID_W defaults, used by the multiplier, this block and the NTT control.
- One sub-module: rr_arbiter (NUM_REQ). Inputs: req vector, enable. Outputs: one-hot grant and encoded id. It contains the ptr register.
- Issue register and tag pipe stay in modmul_arbiter.

Test Plan:
- Single requester 0, a=100, b=1000, handshake at cycle t -> resp_valid=1, resp_id=0, resp_data=100000 at exactly t+1+MULT_LATENCY; all other cycles resp_valid=0.
- Requester 2 only, a=b=12345 -> resp_id=2, resp_data=152399025. Then a=9582, b=6847912 on the next cycle -> product mod Q matches the golden model, one cycle later.
- All 4 requesters valid continuously for 8 cycles -> req_ready sequence 0001,0010,0100,1000,0001,... Responses have ids 0,1,2,3,0,... on consecutive cycles and busy stays 1.
- After a grant to 2 (ptr=3), requesters 1 and 3 request together -> 3 is granted first, 1 on the next cycle.
- Issue 3 operations, assert rst for 1 cycle two cycles later -> no resp_valid for any of them, busy=0 after reset. The first post-reset grant with req_valid=1010 goes to 1.
- No requests for 10 cycles after activity -> resp_valid=0 once the pipe drains, mult_a/mult_b unchanged, busy falls MULT_LATENCY+1 cycles after the last grant.
